// File: rtl/sprite_motion_ctrl.sv
// Horizontal sprite motion controller: steps a sprite across the screen at a
// programmable rate, wrapping or bouncing at the edges, and cycles animation frames.
module sprite_motion_ctrl #(
    parameter int TICK_DIV = 5000000,
    parameter int N_FRAMES = 5,
    parameter int FRAME_W  = 3,
    parameter int STEP_X   = 20,
    parameter int X_MAX    = 640,
    parameter int SPRITE_W = 64,
    parameter int Y_POS    = 300,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               run_i,
    input  logic               mode_i,
    input  logic [1:0]         speed_i,
    output logic [FRAME_W-1:0] action_sel_o,
    output logic [X_W-1:0]     pos_x_o,
    output logic [Y_W-1:0]     pos_y_o,
    output logic               dir_o,
    output logic               step_o,
    output logic               edge_o
);

    localparam int X_LIMIT = X_MAX - SPRITE_W;
    localparam int CNT_W   = $clog2(TICK_DIV + 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] action_q;
    logic [X_W-1:0]     pos_x_q;
    logic               dir_q;
    logic               step_q;
    logic               edge_q;

    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   term;
    logic               tick;
    logic [X_W:0]       pos_ext;
    logic [X_W:0]       pos_sum;
    logic [X_W:0]       step_ext;
    logic [X_W:0]       limit_ext;
    logic [X_W-1:0]     pos_x_d;
    logic               dir_d;
    logic               edge_d;

    // The >= lets a speed increase that strands cnt above the new terminal fire at once.
    always_comb begin
        period = CNT_W'(TICK_DIV) >> speed_i;
        term   = (period == '0) ? '0 : period - 1'b1;
        tick   = (state_q == MOVE) && (cnt_q >= term);
    end

    // Next position if a tick were applied this cycle; one extra bit keeps the sum exact.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        step_ext  = (X_W+1)'(STEP_X);
        limit_ext = (X_W+1)'(X_LIMIT);
        pos_ext   = {1'b0, pos_x_q};
        pos_sum   = pos_ext + step_ext;
        pos_x_d   = pos_x_q;
        dir_d     = dir_q;
        edge_d    = 1'b0;
        if (!mode_i) begin
            dir_d = 1'b0;
            if (pos_sum > limit_ext) begin
                pos_x_d = '0;
                edge_d  = 1'b1;
            end else begin
                pos_x_d = pos_sum[X_W-1:0];
            end
        end else if (!dir_q) begin
            if (pos_sum >= limit_ext) begin
                pos_x_d = X_W'(X_LIMIT);
                dir_d   = 1'b1;
                edge_d  = 1'b1;
            end else begin
                pos_x_d = pos_sum[X_W-1:0];
            end
        end else begin
            if (pos_ext <= step_ext) begin
                pos_x_d = '0;
                dir_d   = 1'b0;
                edge_d  = 1'b1;
            end else begin
                pos_x_d = pos_x_q - X_W'(STEP_X);
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            action_q <= '0;
            pos_x_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    action_q <= '0;
                    step_q   <= 1'b0;
                    edge_q   <= 1'b0;
                    if (run_i) state_q <= MOVE;
                end
                MOVE: begin
                    // A tick on the cycle run drops is still applied before leaving.
                    if (tick) begin
                        cnt_q    <= '0;
                        action_q <= (action_q == LAST_FRAME) ? '0 : action_q + 1'b1;
                        pos_x_q  <= pos_x_d;
                        dir_q    <= dir_d;
                        step_q   <= 1'b1;
                        edge_q   <= edge_d;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        step_q   <= 1'b0;
                        edge_q   <= 1'b0;
                    end
                    if (!run_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign action_sel_o = action_q;
    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = Y_W'(Y_POS);
    assign dir_o        = dir_q;
    assign step_o       = step_q;
    assign edge_o       = edge_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with a short tick period and a 100-pixel screen.
module tb_sprite_motion_ctrl;

    localparam int TICK_DIV = 8;
    localparam int N_FRAMES = 5;
    localparam int FRAME_W  = 3;
    localparam int STEP_X   = 20;
    localparam int X_MAX    = 100;
    localparam int SPRITE_W = 20;
    localparam int Y_POS    = 300;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    logic               pixel_clk = 1'b0;
    logic               reset     = 1'b1;
    logic               run       = 1'b0;
    logic               mode      = 1'b0;
    logic [1:0]         speed     = 2'd0;
    logic [FRAME_W-1:0] action_sel;
    logic [X_W-1:0]     pos_x;
    logic [Y_W-1:0]     pos_y;
    logic               dir;
    logic               step;
    logic               edge_p;

    int n_vec = 0;
    int n_bad = 0;

    sprite_motion_ctrl #(
        .TICK_DIV(TICK_DIV), .N_FRAMES(N_FRAMES), .FRAME_W(FRAME_W), .STEP_X(STEP_X),
        .X_MAX(X_MAX), .SPRITE_W(SPRITE_W), .Y_POS(Y_POS), .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .run_i        (run),
        .mode_i       (mode),
        .speed_i      (speed),
        .action_sel_o (action_sel),
        .pos_x_o      (pos_x),
        .pos_y_o      (pos_y),
        .dir_o        (dir),
        .step_o       (step),
        .edge_o       (edge_p)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step && n < 64);
        if (!step) check("step_timeout", 0, 1);
    endtask

    task automatic exp_step(input string tag, input int gap, input int px, input int act,
                            input int d, input int e);
        int n;
        wait_step(n);
        check({tag, "_gap"}, n, gap);
        check({tag, "_pos"}, int'(pos_x), px);
        check({tag, "_act"}, int'(action_sel), act);
        check({tag, "_dir"}, int'(dir), d);
        check({tag, "_edge"}, int'(edge_p), e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos"}, int'(pos_x), 0);
        check({tag, "_act"}, int'(action_sel), 0);
        check({tag, "_dir"}, int'(dir), 0);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_edge"}, int'(edge_p), 0);
        check({tag, "_posy"}, int'(pos_y), Y_POS);
    endtask

    int wrap_pos [7] = '{40, 60, 80, 0, 20, 40, 60};
    int wrap_act [7] = '{2, 3, 4, 0, 1, 2, 3};
    int wrap_edge[7] = '{0, 0, 0, 1, 0, 0, 0};
    int bnc_pos  [6] = '{80, 60, 40, 20, 0, 20};
    int bnc_act  [6] = '{4, 0, 1, 2, 3, 4};
    int bnc_dir  [6] = '{1, 1, 1, 1, 0, 0};
    int bnc_edge [6] = '{1, 0, 0, 0, 1, 0};

    initial begin
        cyc(3);
        check_reset_vals("rst");

        // Release reset and start running in wrap mode at full period.
        reset = 1'b0;
        run   = 1'b1;
        cyc();
        exp_step("first", 8, 20, 1, 0, 0);
        cyc();
        check("step_width", int'(step), 0);

        for (int i = 0; i < 7; i++)
            exp_step($sformatf("wrap%0d", i), (i == 0) ? 7 : 8,
                     wrap_pos[i], wrap_act[i], 0, wrap_edge[i]);

        mode = 1'b1;
        for (int i = 0; i < 6; i++)
            exp_step($sformatf("bnc%0d", i), 8, bnc_pos[i], bnc_act[i], bnc_dir[i], bnc_edge[i]);

        speed = 2'd2;
        exp_step("spd2_a", 2, 40, 0, 0, 0);
        exp_step("spd2_b", 2, 60, 1, 0, 0);

        // Counter reaches 5 at full period, then the period drops to one cycle.
        speed = 2'd0;
        cyc(5);
        speed = 2'd3;
        exp_step("spd3_a", 1, 80, 2, 1, 1);
        exp_step("spd3_b", 1, 60, 3, 1, 0);
        exp_step("spd3_c", 1, 40, 4, 1, 0);

        speed = 2'd0;
        cyc(4);
        run = 1'b0;
        cyc(2);
        check("idle_act", int'(action_sel), 0);
        check("idle_pos", int'(pos_x), 40);
        check("idle_dir", int'(dir), 1);
        check("idle_step", int'(step), 0);
        cyc(3);
        check("idle_hold_pos", int'(pos_x), 40);
        check("idle_hold_step", int'(step), 0);

        run = 1'b1;
        cyc();
        exp_step("rerun", 8, 20, 1, 1, 0);

        cyc(3);
        reset = 1'b1;
        cyc();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        run   = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
